// File: rtl/led_mode_ctrl_if.sv
// Board-side key/LED signal bundle for led_mode_ctrl.
// The slave modport is the controller side; master is the board/bench side.
interface led_mode_ctrl_if;
    logic [1:0] key;
    logic [1:0] led;
    logic [2:0] mode;
    logic       speed_fast;

    modport master (output key, input led, input mode, input speed_fast);
    modport slave  (input key, output led, output mode, output speed_fast);
endinterface

// File: rtl/led_mode_ctrl.sv
// Two-key LED controller: debounced KEY0 steps the display mode, KEY1 toggles
// blink speed; a shared half-period timer supplies the blink phase.
module led_mode_ctrl #(
    parameter logic [19:0] DEBOUNCE_MAX = 20'd1000000,
    parameter logic [24:0] BLINK_SLOW   = 25'd25000000,
    parameter logic [24:0] BLINK_FAST   = 25'd6250000
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    led_mode_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_SINGLE = 3'd1,
        S_ALT    = 3'd2,
        S_SYNC   = 3'd3,
        S_ON     = 3'd4
    } mode_t;

    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_stable;
    logic [1:0]  r_press;
    logic [19:0] r_db_cnt [2];

    mode_t       r_state;
    mode_t       w_state_nxt;
    logic        r_speed_fast;
    logic [24:0] r_blink_cnt;
    logic        r_phase;
    logic [24:0] w_period;
    logic [1:0]  r_led;
    logic [1:0]  w_led_nxt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1     <= '1;
            r_sync2     <= '1;
            r_stable    <= '1;
            r_press     <= '0;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_sync1 <= bus.key;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_db_cnt[i] == DEBOUNCE_MAX - 20'd1) begin
                        r_stable[i] <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                        // A differing level of 0 means stable was 1: a press, never a release.
                        r_press[i]  <= ~r_sync2[i];
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 20'd1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OFF:    if (r_press[0]) w_state_nxt = S_SINGLE;
            S_SINGLE: if (r_press[0]) w_state_nxt = S_ALT;
            S_ALT:    if (r_press[0]) w_state_nxt = S_SYNC;
            S_SYNC:   if (r_press[0]) w_state_nxt = S_ON;
            S_ON:     if (r_press[0]) w_state_nxt = S_OFF;
            default:  w_state_nxt = S_OFF;
        endcase
    end

    assign w_period = r_speed_fast ? BLINK_FAST : BLINK_SLOW;

    // Any press restarts the blink from phase 0, overriding a wrap on the same edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_speed_fast <= 1'b0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b0;
        end else begin
            if (r_press[1]) begin
                r_speed_fast <= ~r_speed_fast;
            end
            if (|r_press) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (r_blink_cnt == w_period - 25'd1) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 25'd1;
            end
        end
    end

    always_comb begin
        w_led_nxt = 2'b00;
        case (r_state)
            S_SINGLE: w_led_nxt = {1'b0, r_phase};
            S_ALT:    w_led_nxt = r_phase ? 2'b10 : 2'b01;
            S_SYNC:   w_led_nxt = r_phase ? 2'b11 : 2'b00;
            S_ON:     w_led_nxt = 2'b11;
            default:  w_led_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign bus.led        = r_led;
    assign bus.mode       = r_state;
    assign bus.speed_fast = r_speed_fast;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: stimulus queues the expected output
// changes (value + cycles since previous change); a negedge monitor pops on every change.
module tb_led_mode_ctrl;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(
        .DEBOUNCE_MAX (20'd4),
        .BLINK_SLOW   (25'd8),
        .BLINK_FAST   (25'd2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]  led;
        logic [2:0]  mode;
        logic        spd;
        int unsigned gap;
    } exp_t;

    exp_t        q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic ev(input logic [1:0] l, input logic [2:0] m, input logic s, input int unsigned g);
        exp_t e;
        e.led  = l;
        e.mode = m;
        e.spd  = s;
        e.gap  = g;
        q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [1:0] l, input logic [2:0] m, input logic s);
        total++;
        if (bus.led !== l || bus.mode !== m || bus.speed_fast !== s) begin
            bad++;
            $display("FAIL %s: got led=%b mode=%0d spd=%b, required led=%b mode=%0d spd=%b",
                     name, bus.led, bus.mode, bus.speed_fast, l, m, s);
        end
    endtask

    // Monitor: every observed output change must match the next queued entry.
    logic [1:0]  p_led  = 2'b00;
    logic [2:0]  p_mode = 3'd0;
    logic        p_spd  = 1'b0;
    int unsigned cyc    = 0;
    int unsigned last   = 0;
    int unsigned evn    = 0;

    initial begin
        exp_t        e;
        int unsigned gap;
        forever begin
            @(negedge sys_clk);
            cyc++;
            if (bus.led !== p_led || bus.mode !== p_mode || bus.speed_fast !== p_spd) begin
                total++;
                evn++;
                gap = cyc - last;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change #%0d: got led=%b mode=%0d spd=%b, required no change",
                             evn, bus.led, bus.mode, bus.speed_fast);
                end else begin
                    e = q.pop_front();
                    if (bus.led !== e.led || bus.mode !== e.mode || bus.speed_fast !== e.spd ||
                        (e.gap != 0 && gap != e.gap)) begin
                        bad++;
                        $display("FAIL event #%0d: got led=%b mode=%0d spd=%b gap=%0d, required led=%b mode=%0d spd=%b gap=%0d",
                                 evn, bus.led, bus.mode, bus.speed_fast, gap, e.led, e.mode, e.spd, e.gap);
                    end
                end
                last   = cyc;
                p_led  = bus.led;
                p_mode = bus.mode;
                p_spd  = bus.speed_fast;
            end
        end
    end

    // Called at posedge+1; holds keys k low for 'hold' edges, then idles.
    task automatic press(input logic [1:0] k, input int unsigned hold, input int unsigned idle);
        bus.key = ~k;
        repeat (hold) @(posedge sys_clk);
        #1;
        bus.key = 2'b11;
        repeat (idle) @(posedge sys_clk);
        #1;
    endtask

    // Called at posedge+1; asserts reset after the negedge sample, before the next posedge.
    task automatic do_reset(input logic [1:0] l, input logic [2:0] m, input logic s);
        #6;
        check_now("pre_reset", l, m, s);
        sys_rst_n = 1'b0;
        #1;
        check_now("async_reset", 2'b00, 3'd0, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        bus.key = 2'b00;
        repeat (5) begin
            @(negedge sys_clk);
            check_now("reset_hold", 2'b00, 3'd0, 1'b0);
        end
        @(posedge sys_clk);
        #1;
        bus.key   = 2'b11;
        sys_rst_n = 1'b1;
        repeat (50) @(posedge sys_clk);
        #1;
        check_now("idle_after_reset", 2'b00, 3'd0, 1'b0);

        // Bounce, SINGLE slow, ALT slow, ALT fast, then reset mid-blink.
        ev(2'b00, 3'd1, 1'b0, 0);
        ev(2'b01, 3'd1, 1'b0, 9);
        ev(2'b00, 3'd1, 1'b0, 8);
        ev(2'b01, 3'd1, 1'b0, 8);
        ev(2'b00, 3'd1, 1'b0, 8);
        ev(2'b01, 3'd1, 1'b0, 8);
        ev(2'b01, 3'd2, 1'b0, 7);
        ev(2'b10, 3'd2, 1'b0, 9);
        ev(2'b01, 3'd2, 1'b0, 8);
        ev(2'b10, 3'd2, 1'b0, 8);
        ev(2'b01, 3'd2, 1'b0, 8);
        ev(2'b01, 3'd2, 1'b1, 3);
        ev(2'b10, 3'd2, 1'b1, 3);
        ev(2'b01, 3'd2, 1'b1, 2);
        ev(2'b10, 3'd2, 1'b1, 2);
        ev(2'b01, 3'd2, 1'b1, 2);
        ev(2'b10, 3'd2, 1'b1, 2);
        ev(2'b00, 3'd0, 1'b0, 1);

        for (int i = 0; i < 5; i++) begin
            bus.key = 2'b10;
            repeat (3) @(posedge sys_clk);
            #1;
            bus.key = 2'b11;
            repeat (2) @(posedge sys_clk);
            #1;
        end
        press(2'b01, 20, 28);
        press(2'b01, 20, 16);
        press(2'b10, 12, 6);
        do_reset(2'b10, 3'd2, 1'b1);

        // Full mode wrap, simultaneous press, then up to SYNC and reset with led=11.
        ev(2'b00, 3'd1, 1'b0, 0);
        ev(2'b00, 3'd2, 1'b0, 8);
        ev(2'b01, 3'd2, 1'b0, 1);
        ev(2'b01, 3'd3, 1'b0, 7);
        ev(2'b00, 3'd3, 1'b0, 1);
        ev(2'b00, 3'd4, 1'b0, 7);
        ev(2'b11, 3'd4, 1'b0, 1);
        ev(2'b11, 3'd0, 1'b0, 7);
        ev(2'b00, 3'd0, 1'b0, 1);
        ev(2'b00, 3'd1, 1'b1, 7);
        ev(2'b01, 3'd1, 1'b1, 3);
        ev(2'b00, 3'd1, 1'b1, 2);
        ev(2'b01, 3'd1, 1'b1, 2);
        ev(2'b01, 3'd2, 1'b1, 1);
        ev(2'b10, 3'd2, 1'b1, 3);
        ev(2'b01, 3'd2, 1'b1, 2);
        ev(2'b10, 3'd2, 1'b1, 2);
        ev(2'b10, 3'd3, 1'b1, 1);
        ev(2'b00, 3'd3, 1'b1, 1);
        ev(2'b11, 3'd3, 1'b1, 2);
        ev(2'b00, 3'd0, 1'b0, 1);

        for (int i = 0; i < 5; i++) begin
            press(2'b01, 4, 4);
        end
        press(2'b11, 4, 4);
        press(2'b01, 4, 4);
        press(2'b01, 4, 6);
        do_reset(2'b11, 3'd3, 1'b1);

        repeat (10) @(posedge sys_clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_events: got %0d still queued, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Key-driven controller that owns the board's two LEDs and sequences them through a fixed set of display modes.
- Each of two active-low push keys is synchronised and debounced into a single-cycle press event.
- KEY0 steps a mode state machine; KEY1 toggles blink speed.
- A shared half-period timer generates the blink phase that drives the registered LED outputs.
- Sits between the board keys/LEDs and is the single writer of led[1:0].

Parameters:
- DEBOUNCE_MAX, 20'd1000000: cycles a synced key level must differ from its stable level before it is accepted (20 ms @ 50 MHz).
- BLINK_SLOW, 25'd25000000: half-period in cycles, slow speed (0.5 s).
- BLINK_FAST, 25'd6250000: half-period in cycles, fast speed (0.125 s).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous active-low reset.
- key  input  2  raw push keys, active-low (0 = pressed), asynchronous to sys_clk.
- led  output  2  LED drive, 1 = on, registered.
- mode  output  3  current mode state: 0 OFF, 1 SINGLE, 2 ALT, 3 SYNC, 4 ON.
- speed_fast  output  1  1 = BLINK_FAST selected.

Behaviour:
- Reset is asynchronous on sys_rst_n low, clocked on sys_clk. Reset values:
  - led=00, mode=OFF, speed_fast=0.
  - Sync flops=11, stable key levels=11, debounce counters=0.
  - Blink counter=0, phase=0.
  - Reset mid-operation forces these values immediately, with no clock required.
- Synchroniser: 2-flop per key bit. Debounce operates on the 2nd flop output.
- Debounce, per key independently:
  - If sync != stable, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_MAX-1 with sync still != stable, stable <= sync and the counter clears.
  - press pulse: registered, high for exactly one cycle on a stable 1->0 transition only. Releases (0->1) produce no event.
  - A key held down yields exactly one press.
- Mode FSM:
  - Transitions on key0 press only: OFF->SINGLE->ALT->SYNC->ON->OFF (wraps).
  - Illegal encodings 5-7 go to OFF on the next clock.
- Speed: key1 press toggles speed_fast.
- Simultaneous key0 and key1 press in the same cycle: both actions apply in that cycle.
- Blink timer: a 25-bit counter with period P = speed_fast ? BLINK_FAST : BLINK_SLOW.
  - If cnt == P-1, cnt <= 0 and phase <= ~phase; otherwise cnt <= cnt+1.
  - Any accepted press (either key) clears cnt and phase to 0 on that same clock edge. This override takes priority over the wrap.
- LED map, registered from the current mode/phase:
  - OFF: 00.
  - SINGLE: {0, phase}.
  - ALT: phase ? 10 : 01.
  - SYNC: phase ? 11 : 00.
  - ON: 11.
- Latency:
  - A press pulse in cycle t updates mode/speed_fast and clears cnt/phase at edge t+1.
  - led reflects the new mode at edge t+2.
  - From a clean key edge to the press pulse: 2 synchroniser cycles + DEBOUNCE_MAX cycles, ±1.
- Phase steady state: phase toggles every P cycles, so each LED pattern lasts exactly P cycles.
- In OFF and ON the timer keeps running, but the outputs ignore phase.

Test Plan:
Bench parameters: DEBOUNCE_MAX=4, BLINK_SLOW=8, BLINK_FAST=2.
1. Reset: hold sys_rst_n=0 for 5 cycles with key=00 -> led=00, mode=0, speed_fast=0 throughout. After release with key=11 -> outputs unchanged for 50 cycles.
2. Bounce: key[0] low 3 cycles / high 2 cycles, repeated 5 times, then low 20 cycles, then high -> mode stays 0 during the bounce, becomes 1 exactly once, and there is no change on release.
3. SINGLE slow: from mode=1 -> led[1]=0 constantly; led[0] is 0 for 8 cycles then 1 for 8 cycles, repeating. The first 0 interval starts 2 cycles after the press pulse.
4. ALT fast: in mode=2 press key[1] -> speed_fast=1; led=01 immediately after the phase clear, then alternates 01/10 every 2 cycles.
5. Wrap and simultaneous: 5 key0 presses from OFF -> mode steps 1,2,3,4,0. key0 and key1 driven low on the same cycle -> mode increments and speed_fast toggles on the same edge.
6. Reset mid-blink: in SYNC with led=11, drop sys_rst_n between clock edges -> led=00 and mode=0 immediately, before the next sys_clk edge.
